// File: rtl/systolic_weight_loader.sv
// Streams filter weights and biases into the systolic array's shared coefficient
// buses, raising one one-hot write enable per accepted word.
module systolic_weight_loader #(
    parameter int CHANNEL  = 1,
    parameter int FILTERS  = 4,
    parameter int F_WIDTH  = 2,
    parameter int F_D_SIZE = 4,
    parameter int B_D_SIZE = 24
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 clk_en,
    input  logic                                                 start,
    input  logic                                                 abort,
    input  logic                                                 coef_valid,
    output logic                                                 coef_ready,
    input  logic [B_D_SIZE-1:0]                                  coef_data,
    output logic [F_D_SIZE-1:0]                                  filter_o,
    output logic [CHANNEL*F_WIDTH*F_WIDTH-1:0][FILTERS-1:0]      filter_we,
    output logic [B_D_SIZE-1:0]                                  bias_o,
    output logic [FILTERS-1:0]                                   bias_we,
    output logic                                                 busy,
    output logic                                                 done,
    output logic                                                 loaded
);

    localparam int HEIGHT = CHANNEL * F_WIDTH * F_WIDTH;
    localparam int HW     = (HEIGHT  > 1) ? $clog2(HEIGHT)  : 1;
    localparam int FW     = (FILTERS > 1) ? $clog2(FILTERS) : 1;
    localparam logic [HW-1:0] J_LAST = HW'(HEIGHT - 1);
    localparam logic [FW-1:0] F_LAST = FW'(FILTERS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_B,
        S_FLUSH
    } state_t;

    state_t                             r_state;
    logic [FW-1:0]                      r_f;
    logic [HW-1:0]                      r_j;
    logic [F_D_SIZE-1:0]                r_filter_o;
    logic [HEIGHT-1:0][FILTERS-1:0]     r_filter_we;
    logic [B_D_SIZE-1:0]                r_bias_o;
    logic [FILTERS-1:0]                 r_bias_we;
    logic                               r_busy;
    logic                               r_done;
    logic                               r_loaded;

    state_t                             w_state_next;
    logic [FW-1:0]                      w_f_next;
    logic [HW-1:0]                      w_j_next;
    logic                               w_busy_next;
    logic                               w_done_next;
    logic                               w_loaded_next;
    logic                               w_wr_w;
    logic                               w_wr_b;
    logic [HEIGHT-1:0][FILTERS-1:0]     w_filter_we_next;
    logic [FILTERS-1:0]                 w_bias_we_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (clk_en) begin
            r_state <= w_state_next;
        end
    end

    // Everything below is evaluated every cycle but only committed on enabled edges,
    // so a transfer implicitly requires clk_en as well as valid and ready.
    always_comb begin
        w_state_next  = r_state;
        w_f_next      = r_f;
        w_j_next      = r_j;
        w_busy_next   = r_busy;
        w_done_next   = 1'b0;
        w_loaded_next = r_loaded;
        w_wr_w        = 1'b0;
        w_wr_b        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next  = S_LOAD_W;
                    w_f_next      = '0;
                    w_j_next      = '0;
                    w_busy_next   = 1'b1;
                    w_loaded_next = 1'b0;
                end
            end
            S_LOAD_W: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_f_next     = '0;
                    w_j_next     = '0;
                    w_busy_next  = 1'b0;
                end else if (coef_valid) begin
                    w_wr_w = 1'b1;
                    if (r_j == J_LAST) begin
                        w_state_next = S_LOAD_B;
                    end else begin
                        w_j_next = r_j + 1'b1;
                    end
                end
            end
            S_LOAD_B: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_f_next     = '0;
                    w_j_next     = '0;
                    w_busy_next  = 1'b0;
                end else if (coef_valid) begin
                    w_wr_b = 1'b1;
                    if (r_f == F_LAST) begin
                        w_state_next = S_FLUSH;
                    end else begin
                        w_f_next     = r_f + 1'b1;
                        w_j_next     = '0;
                        w_state_next = S_LOAD_W;
                    end
                end
            end
            S_FLUSH: begin
                w_state_next = S_IDLE;
                w_f_next     = '0;
                w_j_next     = '0;
                w_busy_next  = 1'b0;
                // An abort here still cancels: the last bias is out but never confirmed.
                if (!abort) begin
                    w_done_next   = 1'b1;
                    w_loaded_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // One decoder cell per array coefficient; at most one matches the live counters.
    for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_row
        for (genvar gj = 0; gj < FILTERS; gj++) begin : g_col
            assign w_filter_we_next[gi][gj] = w_wr_w && (r_j == HW'(gi)) && (r_f == FW'(gj));
        end
    end

    for (genvar gi = 0; gi < FILTERS; gi++) begin : g_bias
        assign w_bias_we_next[gi] = w_wr_b && (r_f == FW'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f         <= '0;
            r_j         <= '0;
            r_filter_o  <= '0;
            r_filter_we <= '0;
            r_bias_o    <= '0;
            r_bias_we   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_loaded    <= 1'b0;
        end else if (clk_en) begin
            r_f         <= w_f_next;
            r_j         <= w_j_next;
            r_filter_we <= w_filter_we_next;
            r_bias_we   <= w_bias_we_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_loaded    <= w_loaded_next;
            if (w_wr_w) begin
                r_filter_o <= coef_data[F_D_SIZE-1:0];
            end
            if (w_wr_b) begin
                r_bias_o <= coef_data;
            end
        end
    end

    assign coef_ready = (r_state == S_LOAD_W) || (r_state == S_LOAD_B);
    assign filter_o   = r_filter_o;
    assign filter_we  = r_filter_we;
    assign bias_o     = r_bias_o;
    assign bias_we    = r_bias_we;
    assign busy       = r_busy;
    assign done       = r_done;
    assign loaded     = r_loaded;

endmodule

// File: tb/tb_systolic_weight_loader.sv
// Scoreboard bench for systolic_weight_loader: expected array writes are queued
// per load and matched against every enable captured on an enabled edge.
module tb_systolic_weight_loader;

    localparam int H   = 4;
    localparam int FIL = 4;
    localparam int NW  = FIL * (H + 1);

    logic                  clk;
    logic                  rst_n;
    logic                  clk_en;
    logic                  start;
    logic                  abort;
    logic                  coef_valid;
    logic                  coef_ready;
    logic [23:0]           coef_data;
    logic [3:0]            filter_o;
    logic [H-1:0][FIL-1:0] filter_we;
    logic [23:0]           bias_o;
    logic [FIL-1:0]        bias_we;
    logic                  busy;
    logic                  done;
    logic                  loaded;

    typedef struct {
        bit          is_bias;
        int          row;
        int          fil;
        logic [23:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] words[NW];
    int          n_checks = 0;
    int          n_fail   = 0;

    systolic_weight_loader #(
        .CHANNEL(1), .FILTERS(FIL), .F_WIDTH(2), .F_D_SIZE(4), .B_D_SIZE(24)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start), .abort(abort),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
        .filter_o(filter_o), .filter_we(filter_we), .bias_o(bias_o), .bias_we(bias_we),
        .busy(busy), .done(done), .loaded(loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // The array captures on the enabled edge after a write; sample just before it.
    always @(negedge clk) begin
        if (rst_n && clk_en && ((|filter_we) || (|bias_we))) begin
            int row, fil;
            bit is_b;
            exp_t e;
            row = -1; fil = -1;
            is_b = |bias_we;
            for (int r = 0; r < H; r++)
                for (int c = 0; c < FIL; c++)
                    if (filter_we[r][c]) begin row = r; fil = c; end
            for (int c = 0; c < FIL; c++)
                if (bias_we[c]) fil = c;
            n_checks++;
            if ($countones(filter_we) + $countones(bias_we) != 1) begin
                n_fail++;
                $display("FAIL onehot: filter_we=%h bias_we=%b, required exactly one bit", filter_we, bias_we);
            end
            if (is_b) $display("write B fil=%0d bias_o=%h", fil, bias_o);
            else      $display("write W row=%0d fil=%0d filter_o=%h", row, fil, filter_o);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: is_bias=%0d row=%0d fil=%0d, required no write", is_b, row, fil);
            end else begin
                e = exp_q.pop_front();
                if (is_b != e.is_bias || fil != e.fil || (!is_b && row != e.row) ||
                    (is_b ? (bias_o !== e.data) : (filter_o !== e.data[3:0]))) begin
                    n_fail++;
                    $display("FAIL write_match: got bias=%0d row=%0d fil=%0d f=%h b=%h, required bias=%0d row=%0d fil=%0d data=%h",
                             is_b, row, fil, filter_o, bias_o, e.is_bias, e.row, e.fil, e.data);
                end
            end
        end
    end

    task automatic push_load(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.is_bias = ((k % (H + 1)) == H);
            e.row     = k % (H + 1);
            e.fil     = k / (H + 1);
            e.data    = e.is_bias ? words[k] : {20'h0, words[k][3:0]};
            exp_q.push_back(e);
        end
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d writes outstanding, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic begin_load(input int n_expect);
        push_load(n_expect);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || coef_ready !== 1'b1 || loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL start: busy=%b ready=%b loaded=%b, required 1 1 0", busy, coef_ready, loaded);
        end
    endtask

    // Feeds words[first..first+n-1] honouring coef_ready; checks outputs hold across stalls.
    task automatic drive_words(input int first, input int n, input bit toggle,
                               input int stall_lo, input int stall_hi,
                               input int start_lo, input int start_hi);
        int idx, cyc;
        bit xf, en;
        logic [47:0] snap;
        idx = first; cyc = 0;
        while (idx < first + n && cyc < 400) begin
            coef_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            coef_data  = words[idx];
            en         = !(cyc >= stall_lo && cyc <= stall_hi);
            clk_en     = en;
            start      = (cyc >= start_lo && cyc <= start_hi);
            @(negedge clk);
            xf   = coef_valid && coef_ready && clk_en;
            snap = {filter_we, bias_we, filter_o, bias_o};
            @(posedge clk); #1;
            if (!en) begin
                n_checks++;
                if ({filter_we, bias_we, filter_o, bias_o} !== snap) begin
                    n_fail++;
                    $display("FAIL stall_hold: outputs=%h, required %h", {filter_we, bias_we, filter_o, bias_o}, snap);
                end
            end
            if (xf) idx++;
            cyc++;
        end
        coef_valid = 1'b0; clk_en = 1'b1; start = 1'b0;
        n_checks++;
        if (idx != first + n) begin
            n_fail++;
            $display("FAIL stream_timeout: accepted %0d words, required %0d", idx - first, n);
        end
    endtask

    task automatic finish_load(input string name);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_flush: busy=%b done=%b, required 1 0", name, busy, done);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b1 || loaded !== 1'b1 || busy !== 1'b0 || coef_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: done=%b loaded=%b busy=%b ready=%b, required 1 1 0 0", name, done, loaded, busy, coef_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || loaded !== 1'b1 || filter_we !== '0 || bias_we !== '0) begin
            n_fail++;
            $display("FAIL %s_after: done=%b loaded=%b fwe=%h bwe=%b, required 0 1 0 0", name, done, loaded, filter_we, bias_we);
        end
        check_drained({name, "_drained"});
    endtask

    task automatic set_counting_words();
        for (int k = 0; k < NW; k++) words[k] = 24'(k + 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; abort = 1'b0;
        coef_valid = 1'b0; coef_data = '0;
        #12;
        n_checks++;
        if ({filter_o, filter_we, bias_o, bias_we, busy, done, loaded, coef_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: outputs=%h, required 0", {filter_o, filter_we, bias_o, bias_we, busy, done, loaded, coef_ready});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || coef_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b ready=%b, required 0 0", busy, coef_ready);
        end
    endtask

    task automatic test_back_to_back();
        set_counting_words();
        begin_load(NW);
        drive_words(0, NW, 1'b0, -1, -1, -1, -1);
        finish_load("b2b");
    endtask

    task automatic test_stall();
        set_counting_words();
        begin_load(NW);
        drive_words(0, NW, 1'b1, 13, 15, -1, -1);
        finish_load("stall");
    endtask

    task automatic test_data_width();
        for (int k = 0; k < NW; k++) words[k] = 24'($urandom);
        words[0] = 24'hABCDE7;
        words[4] = 24'hFFFFF0;
        begin_load(NW);
        drive_words(0, NW, 1'b0, -1, -1, -1, -1);
        finish_load("width");
        n_checks++;
        if (filter_o !== words[18][3:0] || bias_o !== words[19]) begin
            n_fail++;
            $display("FAIL data_hold: filter_o=%h bias_o=%h, required %h %h", filter_o, bias_o, words[18][3:0], words[19]);
        end
    endtask

    task automatic test_abort();
        set_counting_words();
        begin_load(8);
        drive_words(0, 8, 1'b0, -1, -1, -1, -1);
        coef_valid = 1'b1; coef_data = words[8]; abort = 1'b1;
        @(negedge clk);
        n_checks++;
        if (coef_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ready: ready=%b, required 1", coef_ready);
        end
        @(posedge clk); #1;
        abort = 1'b0; coef_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || loaded !== 1'b0 || done !== 1'b0 || coef_ready !== 1'b0 ||
            filter_we !== '0 || bias_we !== '0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b loaded=%b done=%b ready=%b fwe=%h bwe=%b, required all 0",
                     busy, loaded, done, coef_ready, filter_we, bias_we);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_done: done=%b busy=%b, required 0 0", done, busy);
            end
        end
        check_drained("abort_drained");
        begin_load(NW);
        drive_words(0, NW, 1'b0, -1, -1, -1, -1);
        finish_load("reload");
    endtask

    task automatic test_start_mid_load();
        set_counting_words();
        begin_load(NW);
        drive_words(0, NW, 1'b0, -1, -1, 5, 7);
        finish_load("start_mid");
    endtask

    task automatic test_reset_mid_load();
        set_counting_words();
        begin_load(10);
        drive_words(0, 11, 1'b0, -1, -1, -1, -1);
        coef_valid = 1'b1; coef_data = words[11];
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({filter_o, filter_we, bias_o, bias_we, busy, done, loaded, coef_ready} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: outputs=%h, required 0", {filter_o, filter_we, bias_o, bias_we, busy, done, loaded, coef_ready});
        end
        coef_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || coef_ready !== 1'b0 || loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b ready=%b loaded=%b, required 0 0 0", busy, coef_ready, loaded);
        end
        check_drained("reset_drained");
        begin_load(NW);
        drive_words(0, NW, 1'b0, -1, -1, -1, -1);
        finish_load("post_reset");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_data_width();
        test_abort();
        test_start_mid_load();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
